// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP-1 microsequencer: opcodes, control-word bit
// positions and the fixed microstep words used by the decoder.
package sap_ctrl_pkg;

  localparam int CW_W          = 12;
  localparam int MIN_T_STATES  = 6;
  localparam int MIN_OPCODE_W  = 4;

  // Control-word bit positions, MSB first: CP EP LM CE LI EI LA EA SU EU LB LO
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  typedef logic [CW_W-1:0] cw_t;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Build a control word with a single asserted bit
  function automatic cw_t cw_bit(input int idx);
    cw_t r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Fetch cycle, identical for every opcode
  localparam cw_t CW_T1 = cw_bit(CW_EP) | cw_bit(CW_LM);   // PC -> MAR
  localparam cw_t CW_T2 = cw_bit(CW_CP);                   // PC++
  localparam cw_t CW_T3 = cw_bit(CW_CE) | cw_bit(CW_LI);   // RAM -> IR

  // Execute microsteps
  localparam cw_t CW_OPERAND_ADDR = cw_bit(CW_EI) | cw_bit(CW_LM);                  // IR addr -> MAR
  localparam cw_t CW_LDA_T5       = cw_bit(CW_CE) | cw_bit(CW_LA);                  // RAM -> A
  localparam cw_t CW_ALU_T5       = cw_bit(CW_CE) | cw_bit(CW_LB);                  // RAM -> B
  localparam cw_t CW_ADD_T6       = cw_bit(CW_EU) | cw_bit(CW_LA);                  // A+B -> A
  localparam cw_t CW_SUB_T6       = cw_bit(CW_SU) | cw_bit(CW_EU) | cw_bit(CW_LA);  // A-B -> A
  localparam cw_t CW_OUT_T4       = cw_bit(CW_EA) | cw_bit(CW_LO);                  // A -> OUT

endpackage

// File: rtl/ring_counter.sv
// One-hot ring counter used as the T-state generator. Advances on the
// falling edge so the decoded control word is settled before the datapath's
// rising edge. restart wins over rotation and reloads the first state.
module ring_counter #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         restart,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] FIRST = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Next ring position: reload, rotate left, or hold
  always_comb begin
    q_d = q_q;
    if (restart) begin
      q_d = FIRST;
    end else if (adv) begin
      q_d = {q_q[N-2:0], q_q[N-1]};
    end
  end

  // Ring register, falling-edge clocked with async reset to the first state
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q_q <= FIRST;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/microseq_controller.sv
// SAP-1 control sequencer: ring-counter T-state generator plus opcode/T-state
// decode into the 12-bit control word, with optional early instruction end,
// a sticky halt flag and run/single-step gating.
module microseq_controller
  import sap_ctrl_pkg::*;
#(
  parameter int T_STATES  = 6,
  parameter int OPCODE_W  = 4,
  parameter int EARLY_END = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                step,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CW_W-1:0]     cw_bus,
  output logic [T_STATES-1:0] t_state,
  output logic                instr_done,
  output logic                halted
);

  localparam bit EARLY = (EARLY_END != 0);

  // Elaboration-time parameter sanity checks
  if (T_STATES < MIN_T_STATES) begin : g_bad_t_states
    $error("microseq_controller: T_STATES must be >= 6");
  end
  if (OPCODE_W < MIN_OPCODE_W) begin : g_bad_opcode_w
    $error("microseq_controller: OPCODE_W must be >= 4");
  end

  // Any set bit above the 4-bit opcode field turns the instruction into a NOP
  logic op_hi_nz;
  if (OPCODE_W > 4) begin : g_op_wide
    assign op_hi_nz = |opcode[OPCODE_W-1:4];
  end else begin : g_op_narrow
    assign op_hi_nz = 1'b0;
  end

  logic [3:0] op_lo;
  logic       is_lda, is_add, is_sub, is_out, is_hlt, is_nop;

  assign op_lo  = opcode[3:0];
  assign is_lda = !op_hi_nz && (op_lo == OP_LDA);
  assign is_add = !op_hi_nz && (op_lo == OP_ADD);
  assign is_sub = !op_hi_nz && (op_lo == OP_SUB);
  assign is_out = !op_hi_nz && (op_lo == OP_OUT);
  assign is_hlt = !op_hi_nz && (op_lo == OP_HLT);
  assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

  logic                halted_q;
  logic                halted_d;
  logic [T_STATES-1:0] t_q;
  logic                adv;
  logic                halt_now;
  logic                ring_adv;
  logic                restart;
  logic [CW_W-1:0]     cw_c;
  logic                last_c;

  // A halt freezes the ring at T4, so the ring must not also advance then
  assign adv      = !halted_q && (run || step);
  assign halt_now = adv && t_q[3] && is_hlt;
  assign ring_adv = adv && !halt_now;
  assign restart  = ring_adv && EARLY && instr_done;

  ring_counter #(
    .N (T_STATES)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .adv     (ring_adv),
    .restart (restart),
    .q       (t_q)
  );

  // Halt flag register: sticky until reset, updated with the ring
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Halt flag next state
  always_comb begin
    halted_d = halted_q | halt_now;
  end

  // Microstep decode: control word and last-active-step flag for the live opcode
  always_comb begin
    cw_c   = '0;
    last_c = 1'b0;
    if (t_q[0]) begin
      cw_c = CW_T1;
    end
    if (t_q[1]) begin
      cw_c = CW_T2;
    end
    if (t_q[2]) begin
      cw_c   = CW_T3;
      last_c = is_nop;
    end
    if (t_q[3]) begin
      if (is_lda || is_add || is_sub) begin
        cw_c = CW_OPERAND_ADDR;
      end else if (is_out) begin
        cw_c = CW_OUT_T4;
      end
      last_c = is_out || is_hlt;
    end
    if (t_q[4]) begin
      if (is_lda) begin
        cw_c = CW_LDA_T5;
      end else if (is_add || is_sub) begin
        cw_c = CW_ALU_T5;
      end
      last_c = is_lda;
    end
    if (t_q[5]) begin
      if (is_add) begin
        cw_c = CW_ADD_T6;
      end else if (is_sub) begin
        cw_c = CW_SUB_T6;
      end
      last_c = is_add || is_sub;
    end
  end

  // Outputs: everything is quiet once halted
  always_comb begin
    cw_bus     = '0;
    instr_done = 1'b0;
    if (!halted_q) begin
      cw_bus     = cw_c;
      instr_done = EARLY ? last_c : t_q[T_STATES-1];
    end
  end

  assign t_state = t_q;
  assign halted  = halted_q;

endmodule

// File: doc/microseq_controller.md
Name: microseq_controller

Overview:
Parametrised SAP-1 control sequencer. It replaces the fixed 6-state controller with a ring-counter T-state generator that has configurable depth, optional early instruction termination, a HLT state, and run/single-step control. It decodes the opcode from the IR plus the current T-state into the control word that drives the datapath. The PC, MAR, RAM, IR, accumulator, ALU, B register and output register all consume cw_bus.

Parameters:
- T_STATES, 6, ring length. Must be >= 6; a static check fails elaboration otherwise. States T7..Tn emit 0.
- OPCODE_W, 4, opcode width. Must be >= 4. Any nonzero bit above [3] decodes as NOP.
- EARLY_END, 1, selects instruction length.
  - 1: return to T1 after the last active microstep of the opcode.
  - 0: always run all T_STATES.

Ports:
- clk  in  1  system clock. Sequencer state changes on the falling edge; the datapath latches on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = free-running. 0 = single-step mode.
- step  in  1  in single-step mode, advance one T-state per falling edge at which step=1.
- opcode  in  OPCODE_W  instruction register upper field.
- cw_bus  out  12  active-high control word. Bit order [11..0]: CP EP LM CE LI EI LA EA SU EU LB LO.
- t_state  out  T_STATES  one-hot current T-state. Bit 0 = T1.
- instr_done  out  1  high during the last active T-state of the current instruction.
- halted  out  1  set when HLT executes.

Behaviour:
- Reset (async, any time, including mid-instruction):
  - t_state = T1, halted = 0.
  - cw_bus = 0x600, instr_done = 0.
  - On release, the first advance happens on the next qualifying falling edge.
- Advance enable: adv = !halted & (run | step). Sampled on the negedge. adv=0 holds t_state and cw_bus unchanged.
- cw_bus and instr_done are a combinational decode of the registered t_state and the live opcode. They are stable for the whole high phase before the datapath posedge.
- Fetch, opcode-independent:
  - T1 = EP|LM = 0x600
  - T2 = CP = 0x800
  - T3 = CE|LI = 0x180
- Opcodes 0x0..0xF:
  - LDA 0x0: T4 EI|LM 0x240, T5 CE|LA 0x120. Last = T5.
  - ADD 0x1: T4 0x240, T5 CE|LB 0x102, T6 EU|LA 0x024. Last = T6.
  - SUB 0x2: as ADD, except T6 SU|EU|LA 0x02C. Last = T6.
  - OUT 0xE: T4 EA|LO 0x011. Last = T4.
  - HLT 0xF: T4 emits 0. Last = T4.
  - All other opcodes are NOP: T4+ emit 0. Last = T3.
- EARLY_END=1: on adv while instr_done=1, t_state goes to T1. Otherwise it rotates to the next state.
- EARLY_END=0: instr_done is high only at T[T_STATES]. Rotation always wraps T[T_STATES] to T1.
- HLT: at the negedge where t_state=T4, opcode=HLT and adv=1:
  - halted is set and t_state holds at T4.
  - While halted, cw_bus = 0 and instr_done = 0.
  - run and step are ignored; only rst clears halted.
- Opcode changes are only legal after T3. An opcode change at T4+ re-decodes immediately; no state is kept on the opcode.
- step held high in single-step mode gives one advance per falling edge. There is no edge detection, so the bench drives one-cycle pulses.
- run and step both high is identical to run=1.

Decomposition:
- Package sap_ctrl_pkg:
  - opcode constants: OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT
  - CW bit indices: CW_CP..CW_LO
  - fetch words: CW_T1, CW_T2, CW_T3
  - CW_W = 12
- Sub-module ring_counter: parameter N; inputs clk, rst, adv, restart; output one-hot q.
  - Async reset to bit 0. Clocked on the negedge.
  - restart has priority over rotate and loads bit 0.
- The top level holds the decode and the halt flag.

Test Plan:
1. Reset with run=1, opcode=0x0, EARLY_END=1 -> cw_bus sequence 0x600, 0x800, 0x180, 0x240, 0x120, then 0x600; instr_done high only at T5.
2. opcode=0x2, then 0x1, EARLY_END=1 -> SUB T6 = 0x02C, ADD T6 = 0x024; each wraps to T1 after T6.
3. EARLY_END=0, T_STATES=8, opcode=0xE -> T4 = 0x011, T5..T8 = 0; instr_done at T8; wraps to T1.
4. opcode=0xF -> halted rises after T4; t_state stays 0x08; cw_bus = 0 for 20 cycles despite run=1 and step pulses; rst pulse -> t_state=1, halted=0.
5. run=0, three one-cycle step pulses spaced 4 cycles apart, opcode=0x0 -> t_state 1→2→4→8 only on pulse edges; held between pulses.
6. rst asserted asynchronously mid-T5 of ADD (between clock edges) -> t_state=1 and cw_bus=0x600 immediately; normal fetch resumes after release.
